// File: rtl/mlp_seq_pkg.sv
// Shared constants, state encoding and bus-offset helpers for the time-shared MLP controller.
package mlp_seq_pkg;

   localparam int NUM_A    = 7;
   localparam int WIDTH_A  = 4;
   localparam int NUM_H    = 3;
   localparam int NUM_O    = 3;
   localparam int WIDTH_W  = 8;
   localparam int NUM_W    = NUM_A*NUM_H + NUM_H*NUM_O;
   localparam int WIDTH_B0 = 11;
   localparam int WIDTH_B1 = 14;
   localparam int ACC_W    = 18;
   localparam int H_SHIFT  = 4;
   localparam int OUTWIDTH = 2;

   localparam int H_MAX    = (1 << WIDTH_A) - 1;
   localparam int LATENCY  = NUM_H*(NUM_A+1) + NUM_O*(NUM_H+1);
   localparam int L1_W_OFF = NUM_A*NUM_H;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   localparam int I_W = clog2(NUM_A);
   localparam int J_W = clog2(NUM_H);
   localparam int O_W = clog2(NUM_O);
   localparam int K_W = clog2(NUM_W);

   function automatic int b0_off(input int j);
      return j*WIDTH_B0;
   endfunction

   function automatic int b1_off(input int o);
      return NUM_H*WIDTH_B0 + o*WIDTH_B1;
   endfunction

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_L0_MAC = 3'd1,
      ST_L0_ACT = 3'd2,
      ST_L1_MAC = 3'd3,
      ST_L1_ACT = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/mlp_mac.sv
// Single shared multiply-add: unsigned activation times signed weight, added to the accumulator.
module mlp_mac
   import mlp_seq_pkg::*;
(
   input  logic        [WIDTH_A-1:0] a,
   input  logic signed [WIDTH_W-1:0] w,
   input  logic signed [ACC_W-1:0]   acc_in,
   output logic signed [ACC_W-1:0]   sum
);

   logic signed [ACC_W-1:0] a_ext;
   logic signed [ACC_W-1:0] w_ext;
   logic signed [ACC_W-1:0] prod;

   // Product is kept to ACC_W bits; the accumulator wraps modulo 2^ACC_W anyway.
   always_comb begin
      a_ext = {{(ACC_W-WIDTH_A){1'b0}}, a};
      w_ext = {{(ACC_W-WIDTH_W){w[WIDTH_W-1]}}, w};
      prod  = a_ext * w_ext;
      sum   = acc_in + prod;
   end

endmodule

// File: rtl/mlp_seq_ctrl.sv
// Sequential 7-3-3 quantized MLP: one MAC per cycle, argmax class out via valid/ready.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a sample
// L0_MAC | accumulate x[i]*w for hidden neuron j
// L0_ACT | ReLU, shift and clamp into h[j]; load next bias
// L1_MAC | accumulate h[j]*w for output neuron o
// L1_ACT | compare score with best; load next bias or finish
// DONE   | hold result until out_ready
module mlp_seq_ctrl
   import mlp_seq_pkg::*;
(
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [NUM_A*WIDTH_A-1:0]                inp,
   input  logic [NUM_W*WIDTH_W-1:0]                weights,
   input  logic [NUM_H*WIDTH_B0+NUM_O*WIDTH_B1-1:0] biases,
   output logic                                    out_valid,
   input  logic                                    out_ready,
   output logic [OUTWIDTH-1:0]                     out
);

   state_t                      state, state_nx;
   logic [NUM_A*WIDTH_A-1:0]    x_q, x_nx;
   logic signed [ACC_W-1:0]     acc, acc_nx;
   logic signed [ACC_W-1:0]     best, best_nx;
   logic [I_W-1:0]              i_q, i_nx;
   logic [J_W-1:0]              j_q, j_nx, j_inc;
   logic [O_W-1:0]              o_q, o_nx, o_inc;
   logic [WIDTH_A-1:0]          h_q [NUM_H];
   logic [WIDTH_A-1:0]          h_nx [NUM_H];
   logic [OUTWIDTH-1:0]         idx, idx_nx, out_nx;
   logic                        out_valid_nx;

   logic [WIDTH_A-1:0]          x_arr [NUM_A];
   logic signed [WIDTH_W-1:0]   w_arr [NUM_W];
   logic signed [ACC_W-1:0]     b0_ext [NUM_H];
   logic signed [ACC_W-1:0]     b1_ext [NUM_O];

   logic [K_W-1:0]              w_k;
   logic [WIDTH_A-1:0]          mac_a;
   logic signed [WIDTH_W-1:0]   mac_w;
   logic signed [ACC_W-1:0]     mac_sum;
   logic signed [ACC_W-1:0]     relu, shifted;
   logic [WIDTH_A-1:0]          h_val;
   logic                        better;

   for (genvar g = 0; g < NUM_A; g++) begin : g_x
      assign x_arr[g] = x_q[g*WIDTH_A +: WIDTH_A];
   end
   for (genvar g = 0; g < NUM_W; g++) begin : g_w
      assign w_arr[g] = weights[g*WIDTH_W +: WIDTH_W];
   end
   for (genvar g = 0; g < NUM_H; g++) begin : g_b0
      assign b0_ext[g] = ACC_W'($signed(biases[b0_off(g) +: WIDTH_B0]));
   end
   for (genvar g = 0; g < NUM_O; g++) begin : g_b1
      assign b1_ext[g] = ACC_W'($signed(biases[b1_off(g) +: WIDTH_B1]));
   end

   // The j counter walks hidden neurons in layer 0 and hidden inputs in layer 1.
   always_comb begin
      if (state == ST_L1_MAC) begin
         mac_a = h_q[j_q];
         w_k   = K_W'(L1_W_OFF) + K_W'(o_q)*K_W'(NUM_H) + K_W'(j_q);
      end else begin
         mac_a = x_arr[i_q];
         w_k   = K_W'(j_q)*K_W'(NUM_A) + K_W'(i_q);
      end
      mac_w = w_arr[w_k];
   end

   mlp_mac u_mac (
      .a      (mac_a),
      .w      (mac_w),
      .acc_in (acc),
      .sum    (mac_sum)
   );

   always_comb begin
      relu    = acc[ACC_W-1] ? '0 : acc;
      shifted = relu >>> H_SHIFT;
      h_val   = (shifted > ACC_W'(H_MAX)) ? WIDTH_A'(H_MAX) : shifted[WIDTH_A-1:0];
      better  = (o_q == '0) || (acc > best);
   end

   assign in_ready = (state == ST_IDLE);

   always_comb begin
      state_nx     = state;
      x_nx         = x_q;
      acc_nx       = acc;
      best_nx      = best;
      i_nx         = i_q;
      j_nx         = j_q;
      o_nx         = o_q;
      h_nx         = h_q;
      idx_nx       = idx;
      out_nx       = out;
      out_valid_nx = out_valid;
      j_inc        = j_q + J_W'(1);
      o_inc        = o_q + O_W'(1);
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               x_nx     = inp;
               acc_nx   = b0_ext[0];
               i_nx     = '0;
               j_nx     = '0;
               state_nx = ST_L0_MAC;
            end
         end
         ST_L0_MAC: begin
            acc_nx = mac_sum;
            if (i_q == I_W'(NUM_A-1)) state_nx = ST_L0_ACT;
            else                      i_nx     = i_q + I_W'(1);
         end
         ST_L0_ACT: begin
            h_nx[j_q] = h_val;
            i_nx      = '0;
            if (j_q != J_W'(NUM_H-1)) begin
               j_nx     = j_inc;
               acc_nx   = b0_ext[j_inc];
               state_nx = ST_L0_MAC;
            end else begin
               j_nx     = '0;
               o_nx     = '0;
               acc_nx   = b1_ext[0];
               state_nx = ST_L1_MAC;
            end
         end
         ST_L1_MAC: begin
            acc_nx = mac_sum;
            if (j_q == J_W'(NUM_H-1)) begin
               j_nx     = '0;
               state_nx = ST_L1_ACT;
            end else begin
               j_nx = j_inc;
            end
         end
         ST_L1_ACT: begin
            if (better) begin
               best_nx = acc;
               idx_nx  = OUTWIDTH'(o_q);
            end
            if (o_q != O_W'(NUM_O-1)) begin
               o_nx     = o_inc;
               acc_nx   = b1_ext[o_inc];
               state_nx = ST_L1_MAC;
            end else begin
               out_nx       = better ? OUTWIDTH'(o_q) : idx;
               out_valid_nx = 1'b1;
               state_nx     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_nx = 1'b0;
               state_nx     = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         x_q       <= '0;
         acc       <= '0;
         best      <= '0;
         i_q       <= '0;
         j_q       <= '0;
         o_q       <= '0;
         idx       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         for (int n = 0; n < NUM_H; n++) h_q[n] <= '0;
      end else begin
         state     <= state_nx;
         x_q       <= x_nx;
         acc       <= acc_nx;
         best      <= best_nx;
         i_q       <= i_nx;
         j_q       <= j_nx;
         o_q       <= o_nx;
         idx       <= idx_nx;
         out       <= out_nx;
         out_valid <= out_valid_nx;
         h_q       <= h_nx;
      end
   end

endmodule
